acc_cpu_gen2: RTL and testbench
===============================

# acc_cpu_gen2

Parametrised multicycle accumulator CPU, successor to the 16-bit/12-bit core. It keeps the 8-opcode memory-reference, register-reference and I/O instruction set, and generalises data width and address width. It adds ready/valid handshakes on keyboard and display, a HLT state and an optional vectored interrupt. It sits between the unified program/data memory and the user I/O pads.

## Interface
- DW, 16: data/instruction width; must satisfy DW ≥ AW+4.
- AW, 12: address width; must be ≥ 12 (register/IO fields occupy instr[11:0]).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- addr  out  AW  memory address register.
- datain  in  DW  memory read data, combinational, valid in the same cycle as en=1, rdwr=0.
- dataout  out  DW  memory write data, valid when en=1, rdwr=1; 0 otherwise.
- en  out  1  memory access strobe.
- rdwr  out  1  1 = write (committed at clk edge), 0 = read.
- kb_data  in  8  keyboard byte.
- kb_valid  in  1  keyboard byte available.
- kb_ready  out  1  one-cycle accept pulse.
- disp_data  out  8  display byte.
- disp_valid  out  1  display byte pending.
- disp_ready  in  1  display accepts the byte.
- halted  out  1  core stopped by HLT.

## Operation
- Instruction fields:
  - instr[DW-1] = I (indirect).
  - instr[DW-2:DW-4] = opcode.
  - instr[AW-1:0] = address.
- Opcodes 0–6 (memory reference): AND, ADD, LDA, STA, BUN, BSA, ISZ.
- Opcode 7, I=0 (register reference), bits 11..0:
  - Operations: CLA, CLE, CMA, CME, CIR, CIL, INC, SPA, SNA, SZA, SZE, HLT.
  - Multiple operation bits are applied in that listed order, chained within one cycle.
  - Skips OR together and advance pc by 1.
- Opcode 7, I=1 (I/O), bits 11..6: INP, OUT, SKI, SKO, ION, IOF.
- States: FETCH0 → FETCH1 → DECODE → [INDIRECT] → EXEC1..EXEC3 → FETCH0, plus INTR1, INTR2, HALT.
  - FETCH0: addr←pc.
  - FETCH1: read; ir←datain; pc←pc+1.
  - DECODE: addr←ir[AW-1:0]. INDIRECT is entered only if I=1 and opcode≠7.
  - INDIRECT: read; addr←datain[AW-1:0].
- EXEC sequences:
  - AND/ADD/LDA: read dr; then ac←ac&dr / {e,ac}←ac+dr (carry into e, DW-bit add) / ac←dr.
  - STA: write ac.
  - BUN: pc←addr.
  - BSA: write zero-extended pc at addr, addr←addr+1; then pc←addr.
  - ISZ: read dr; dr←dr+1; write dr, and pc←pc+1 if dr==0.
- CIR/CIL rotate the (DW+1)-bit {e,ac} word.
- pc and addr wrap modulo 2^AW.
- INP:
  - If kb_valid: ac[7:0]←kb_data, ac upper bits unchanged, kb_ready=1 for one cycle.
  - If kb_valid=0: no-op.
- SKI: skip if kb_valid.
- OUT:
  - If disp_valid=0 at the start of the cycle: disp_data←ac[7:0], disp_valid←1.
  - Otherwise ignored.
- Display handshake: disp_valid clears on the edge where disp_valid && disp_ready. That edge sets the sticky out_done flag; the next OUT clears it.
- SKO: skip if disp_valid=0.
- HLT: enter HALT, halted=1. No memory activity until rst.
- rst at any state: all registers cleared, state FETCH0; an in-flight write does not commit.

## Timing
- Cycles per instruction:
  - AND/ADD/LDA: 5, or 6 with I=1.
  - STA/BUN: 4, or 5 with I=1.
  - BSA: 5, or 6 with I=1.
  - ISZ: 6, or 7 with I=1.
  - Register/IO: 3.
- en=1 only in FETCH1, INDIRECT and the memory read/write EXEC cycles. rdwr=1 only in write cycles.
- Reset values: addr=0, dataout=0, en=0, rdwr=0, kb_ready=0, disp_data=0, disp_valid=0, halted=0. Internal pc=0, ac=0, e=0, ir=0, dr=0, IEN=0, out_done=0.
- kb_ready asserts in the INP execute cycle; kb_data is sampled on that edge.

## Configuration
- ACC_CPU_IRQ_EN defined:
  - IEN flag: ION sets it, IOF clears it.
  - In FETCH0, if IEN && (kb_valid || out_done), go to INTR1 instead of FETCH1.
  - INTR1: write pc to mem[0].
  - INTR2: pc←1, IEN←0, then FETCH0.
  - An interrupt is never taken mid-instruction or in HALT.
- ACC_CPU_IRQ_EN undefined:
  - ION/IOF execute as 3-cycle no-ops.
  - No INTR states are synthesised.

## Test plan
- mem[0..5] = 2004,1005,3006,7001,FFFF,0002 (hex) → mem[6]=0001, e=1, halted=1 after 17 cycles, no further en.
- mem[0]=A010, mem[010]=0020, mem[020]=1234 → ac=1234 after exactly 6 cycles; addr=020 in the read.
- mem[0]=6007, mem[7]=FFFF, mem[1]=7001, mem[2]=7001 → mem[7]=0000, pc skips the word at 1, halt fetched from 2.
- kb_valid=1, kb_data=41, INP → ac[7:0]=41, one kb_ready pulse. Two OUTs with disp_ready=0 → disp_data holds the first byte; the second OUT is ignored.
- ACC_CPU_IRQ_EN defined; ION executed at pc=5, kb_valid raised → mem[0]=0006, pc=1, IEN=0.
- rst asserted during the STA write cycle → target word unchanged, all outputs at reset values, refetch from address 0.

Source files
------------

// File: rtl/acc_cpu_gen2.sv
// acc_cpu_gen2: parametrised multicycle accumulator CPU with ready/valid keyboard/display and HLT.
// Define ACC_CPU_IRQ_EN to build the vectored interrupt (IEN flag, INTR1/INTR2 states).
module acc_cpu_gen2 #(
    parameter int DW = 16,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] addr,
    input  logic [DW-1:0] datain,
    output logic [DW-1:0] dataout,
    output logic          en,
    output logic          rdwr,
    input  logic [7:0]    kb_data,
    input  logic          kb_valid,
    output logic          kb_ready,
    output logic [7:0]    disp_data,
    output logic          disp_valid,
    input  logic          disp_ready,
    output logic          halted
);
    typedef enum logic [3:0] {
        FETCH0, FETCH1, DECODE, INDIRECT, EXEC1, EXEC2, EXEC3,
`ifdef ACC_CPU_IRQ_EN
        INTR1, INTR2,
`endif
        HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_AND, OP_ADD, OP_LDA, OP_STA, OP_BUN, OP_BSA, OP_ISZ, OP_REG
    } op_t;

    localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] ONE_D = {{(DW-1){1'b0}}, 1'b1};

    state_t        state_q;
    logic [AW-1:0] pc_q, addr_q;
    logic [DW-1:0] ac_q, ir_q, dr_q, dataout_q;
    logic          e_q, en_q, rdwr_q, disp_valid_q, halted_q;
    logic [7:0]    disp_data_q;
`ifdef ACC_CPU_IRQ_EN
    logic          ien_q, out_done_q;
`endif

    op_t           op;
    logic          ind;
    logic [DW-1:0] pc_ext;
    logic [DW:0]   sum, rr;
    logic          rr_skip;
    logic          x_en, x_wr;
    logic [DW-1:0] x_dout;

    assign op     = op_t'(ir_q[DW-2:DW-4]);
    assign ind    = ir_q[DW-1];
    assign pc_ext = {{(DW-AW){1'b0}}, pc_q};
    assign sum    = {1'b0, ac_q} + {1'b0, dr_q};

    // Register-reference bits 11..1 applied in order on the chained {e,ac} value
    always_comb begin
        rr = {e_q, ac_q};
        if (ir_q[11]) rr[DW-1:0] = '0;
        if (ir_q[10]) rr[DW] = 1'b0;
        if (ir_q[9])  rr[DW-1:0] = ~rr[DW-1:0];
        if (ir_q[8])  rr[DW] = ~rr[DW];
        if (ir_q[7])  rr = {rr[0], rr[DW:1]};
        if (ir_q[6])  rr = {rr[DW-1:0], rr[DW]};
        if (ir_q[5])  rr[DW-1:0] = rr[DW-1:0] + ONE_D;
        rr_skip = (ir_q[4] && !rr[DW-1]) || (ir_q[3] && rr[DW-1]) ||
                  (ir_q[2] && (rr[DW-1:0] == '0)) || (ir_q[1] && !rr[DW]);
    end

    // Bus strobes for the first execute cycle, reused from DECODE and INDIRECT
    always_comb begin
        x_en   = 1'b0;
        x_wr   = 1'b0;
        x_dout = '0;
        case (op)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: x_en = 1'b1;
            OP_STA: begin x_en = 1'b1; x_wr = 1'b1; x_dout = ac_q;   end
            OP_BSA: begin x_en = 1'b1; x_wr = 1'b1; x_dout = pc_ext; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH0;
            pc_q         <= '0;
            addr_q       <= '0;
            ac_q         <= '0;
            e_q          <= 1'b0;
            ir_q         <= '0;
            dr_q         <= '0;
            en_q         <= 1'b0;
            rdwr_q       <= 1'b0;
            dataout_q    <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            halted_q     <= 1'b0;
`ifdef ACC_CPU_IRQ_EN
            ien_q        <= 1'b0;
            out_done_q   <= 1'b0;
`endif
        end else begin
            en_q      <= 1'b0;
            rdwr_q    <= 1'b0;
            dataout_q <= '0;
            case (state_q)
                FETCH0: begin
                    addr_q <= pc_q;
`ifdef ACC_CPU_IRQ_EN
                    if (ien_q && (kb_valid || out_done_q)) begin
                        state_q   <= INTR1;
                        addr_q    <= '0;
                        en_q      <= 1'b1;
                        rdwr_q    <= 1'b1;
                        dataout_q <= pc_ext;
                    end else
`endif
                    begin
                        state_q <= FETCH1;
                        en_q    <= 1'b1;
                    end
                end
                FETCH1: begin
                    ir_q    <= datain;
                    pc_q    <= pc_q + ONE_A;
                    state_q <= DECODE;
                end
                DECODE: begin
                    addr_q <= ir_q[AW-1:0];
                    if (op == OP_REG) begin
                        state_q <= FETCH0;
                        if (!ind) begin
                            ac_q <= rr[DW-1:0];
                            e_q  <= rr[DW];
                            if (rr_skip) pc_q <= pc_q + ONE_A;
                            if (ir_q[0]) begin
                                state_q  <= HALT;
                                halted_q <= 1'b1;
                            end
                        end else begin
                            if (ir_q[11] && kb_valid) ac_q[7:0] <= kb_data;
                            if (ir_q[10]) begin
`ifdef ACC_CPU_IRQ_EN
                                out_done_q <= 1'b0;
`endif
                                if (!disp_valid_q) begin
                                    disp_data_q  <= ac_q[7:0];
                                    disp_valid_q <= 1'b1;
                                end
                            end
                            if ((ir_q[9] && kb_valid) || (ir_q[8] && !disp_valid_q))
                                pc_q <= pc_q + ONE_A;
`ifdef ACC_CPU_IRQ_EN
                            if (ir_q[7]) ien_q <= 1'b1;
                            if (ir_q[6]) ien_q <= 1'b0;
`endif
                        end
                    end else if (ind) begin
                        state_q <= INDIRECT;
                        en_q    <= 1'b1;
                    end else begin
                        state_q   <= EXEC1;
                        en_q      <= x_en;
                        rdwr_q    <= x_wr;
                        dataout_q <= x_dout;
                    end
                end
                INDIRECT: begin
                    addr_q    <= datain[AW-1:0];
                    state_q   <= EXEC1;
                    en_q      <= x_en;
                    rdwr_q    <= x_wr;
                    dataout_q <= x_dout;
                end
                EXEC1: begin
                    case (op)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            dr_q    <= datain;
                            state_q <= EXEC2;
                        end
                        OP_BUN: begin
                            pc_q    <= addr_q;
                            state_q <= FETCH0;
                        end
                        OP_BSA: begin
                            addr_q  <= addr_q + ONE_A;
                            state_q <= EXEC2;
                        end
                        default: state_q <= FETCH0;
                    endcase
                end
                EXEC2: begin
                    state_q <= FETCH0;
                    case (op)
                        OP_AND: ac_q <= ac_q & dr_q;
                        OP_ADD: {e_q, ac_q} <= sum;
                        OP_LDA: ac_q <= dr_q;
                        OP_BSA: pc_q <= addr_q;
                        OP_ISZ: begin
                            dr_q      <= dr_q + ONE_D;
                            en_q      <= 1'b1;
                            rdwr_q    <= 1'b1;
                            dataout_q <= dr_q + ONE_D;
                            state_q   <= EXEC3;
                        end
                        default: ;
                    endcase
                end
                EXEC3: begin
                    if (dr_q == '0) pc_q <= pc_q + ONE_A;
                    state_q <= FETCH0;
                end
`ifdef ACC_CPU_IRQ_EN
                INTR1: state_q <= INTR2;
                INTR2: begin
                    pc_q    <= ONE_A;
                    ien_q   <= 1'b0;
                    state_q <= FETCH0;
                end
`endif
                HALT:    state_q <= HALT;
                default: state_q <= FETCH0;
            endcase

            // Display acceptance wins over an OUT in the same cycle
            if (disp_valid_q && disp_ready) begin
                disp_valid_q <= 1'b0;
`ifdef ACC_CPU_IRQ_EN
                out_done_q   <= 1'b1;
`endif
            end
        end
    end

    assign addr       = addr_q;
    assign dataout    = dataout_q;
    assign en         = en_q;
    assign rdwr       = rdwr_q;
    assign kb_ready   = (state_q == DECODE) && (op == OP_REG) && ind && ir_q[11] && kb_valid;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_acc_cpu_gen2.sv
// Self-checking bench for acc_cpu_gen2: directed programs plus random straight-line programs
// checked against an instruction-level reference model.
module tb_acc_cpu_gen2;
    localparam int DW = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic [DW-1:0] datain, dataout;
    logic          en, rdwr;
    logic [7:0]    kb_data;
    logic          kb_valid, kb_ready;
    logic [7:0]    disp_data;
    logic          disp_valid, disp_ready, halted;

    logic [15:0]   mem [0:4095];
    logic          ld_we;
    logic [11:0]   ld_a;
    logic [15:0]   ld_d;
    int unsigned   img [0:4095];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acc_cpu_gen2 #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .addr(addr), .datain(datain), .dataout(dataout),
        .en(en), .rdwr(rdwr), .kb_data(kb_data), .kb_valid(kb_valid), .kb_ready(kb_ready),
        .disp_data(disp_data), .disp_valid(disp_valid), .disp_ready(disp_ready), .halted(halted)
    );

    assign datain = mem[addr];

    always @(posedge clk) begin
        if (ld_we) mem[ld_a] <= ld_d;
        else if (en && rdwr) mem[addr] <= dataout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        ld_a = a; ld_d = d; ld_we = 1'b1;
        tick();
        ld_we = 1'b0;
    endtask

    task automatic reset_cpu();
        rst = 1'b1; kb_valid = 1'b0; disp_ready = 1'b0;
        tick();
    endtask

    task automatic run_until_halt(input int max, output int cyc);
        cyc = 0;
        while (halted !== 1'b1 && cyc < max) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; #2; rst = 1'b1; #1;
        checks++; if (addr !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h expected 000", addr); end
        checks++; if (dataout !== 16'h0000) begin errors++; $display("FAIL reset_dataout: got %h expected 0000", dataout); end
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", en); end
        checks++; if (rdwr !== 1'b0) begin errors++; $display("FAIL reset_rdwr: got %b expected 0", rdwr); end
        checks++; if (kb_ready !== 1'b0) begin errors++; $display("FAIL reset_kb_ready: got %b expected 0", kb_ready); end
        checks++; if (disp_data !== 8'h00) begin errors++; $display("FAIL reset_disp_data: got %h expected 00", disp_data); end
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid: got %b expected 0", disp_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        tick(); tick();
        checks++; if (en !== 1'b0 || addr !== 12'h000) begin
            errors++; $display("FAIL reset_held: got en=%b addr=%h expected en=0 addr=000", en, addr);
        end
    endtask

    task automatic test_basic_program();
        int cyc, nen;
        reset_cpu();
        poke(12'h000, 16'h2004); poke(12'h001, 16'h1005); poke(12'h002, 16'h3006);
        poke(12'h003, 16'h7001); poke(12'h004, 16'hFFFF); poke(12'h005, 16'h0002);
        poke(12'h006, 16'h5555);
        rst = 1'b0;
        run_until_halt(60, cyc);
        checks++; if (cyc != 17) begin errors++; $display("FAIL prog_cycles: got %0d expected 17", cyc); end
        checks++; if (mem[6] !== 16'h0001) begin errors++; $display("FAIL prog_sum: got %h expected 0001", mem[6]); end
        checks++; if (dut.e_q !== 1'b1) begin errors++; $display("FAIL prog_carry: got %b expected 1", dut.e_q); end
        nen = 0;
        repeat (10) begin tick(); if (en !== 1'b0) nen++; end
        checks++; if (nen != 0 || halted !== 1'b1) begin
            errors++; $display("FAIL halt_quiet: got en_cycles=%0d halted=%b expected 0 and 1", nen, halted);
        end
    endtask

    task automatic test_indirect();
        int cyc;
        reset_cpu();
        poke(12'h000, 16'hA010); poke(12'h010, 16'h0020); poke(12'h020, 16'h1234);
        poke(12'h001, 16'h3030); poke(12'h002, 16'h7001); poke(12'h030, 16'h0000);
        rst = 1'b0;
        tick();
        checks++; if (en !== 1'b1 || rdwr !== 1'b0 || addr !== 12'h000) begin
            errors++; $display("FAIL ind_fetch: got en=%b rdwr=%b addr=%h expected 1 0 000", en, rdwr, addr);
        end
        tick(); tick();
        checks++; if (en !== 1'b1 || rdwr !== 1'b0 || addr !== 12'h010) begin
            errors++; $display("FAIL ind_ptr_read: got en=%b rdwr=%b addr=%h expected 1 0 010", en, rdwr, addr);
        end
        tick();
        checks++; if (en !== 1'b1 || rdwr !== 1'b0 || addr !== 12'h020) begin
            errors++; $display("FAIL ind_data_read: got en=%b rdwr=%b addr=%h expected 1 0 020", en, rdwr, addr);
        end
        tick();
        checks++; if (dut.ac_q !== 16'h0000) begin errors++; $display("FAIL ind_ac_early: got %h expected 0000", dut.ac_q); end
        tick();
        checks++; if (dut.ac_q !== 16'h1234) begin errors++; $display("FAIL ind_ac_6cyc: got %h expected 1234", dut.ac_q); end
        run_until_halt(40, cyc);
        checks++; if (mem[12'h030] !== 16'h1234 || halted !== 1'b1) begin
            errors++; $display("FAIL ind_store: got %h halted=%b expected 1234 1", mem[12'h030], halted);
        end
    endtask

    task automatic test_isz_skip();
        reset_cpu();
        poke(12'h000, 16'h6007); poke(12'h007, 16'hFFFF);
        poke(12'h001, 16'h7001); poke(12'h002, 16'h7001);
        rst = 1'b0;
        repeat (5) tick();
        checks++; if (en !== 1'b1 || rdwr !== 1'b1 || addr !== 12'h007 || dataout !== 16'h0000) begin
            errors++; $display("FAIL isz_write: got en=%b rdwr=%b addr=%h data=%h expected 1 1 007 0000", en, rdwr, addr, dataout);
        end
        tick(); tick();
        checks++; if (en !== 1'b1 || rdwr !== 1'b0 || addr !== 12'h002) begin
            errors++; $display("FAIL isz_skip_fetch: got en=%b rdwr=%b addr=%h expected 1 0 002", en, rdwr, addr);
        end
        tick();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL isz_halt_early: got %b expected 0", halted); end
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL isz_halt: got %b expected 1", halted); end
        checks++; if (mem[7] !== 16'h0000) begin errors++; $display("FAIL isz_value: got %h expected 0000", mem[7]); end
    endtask

    task automatic test_io_handshake();
        int pulses, first;
        reset_cpu();
        poke(12'h000, 16'hF800); poke(12'h001, 16'h3040); poke(12'h002, 16'hF400);
        poke(12'h003, 16'h7020); poke(12'h004, 16'hF400); poke(12'h005, 16'h7001);
        poke(12'h040, 16'hFFFF);
        kb_valid = 1'b1; kb_data = 8'h41; disp_ready = 1'b0;
        rst = 1'b0;
        pulses = 0; first = -1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (kb_ready === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        kb_valid = 1'b0;
        checks++; if (pulses != 1) begin errors++; $display("FAIL kb_ready_pulses: got %0d expected 1", pulses); end
        checks++; if (first != 2) begin errors++; $display("FAIL kb_ready_cycle: got %0d expected 2", first); end
        checks++; if (mem[12'h040] !== 16'h0041) begin errors++; $display("FAIL inp_value: got %h expected 0041", mem[12'h040]); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL io_halt: got %b expected 1", halted); end
        checks++; if (disp_valid !== 1'b1 || disp_data !== 8'h41) begin
            errors++; $display("FAIL out_hold: got valid=%b data=%h expected 1 41", disp_valid, disp_data);
        end
        disp_ready = 1'b1;
        tick();
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL disp_accept: got %b expected 0", disp_valid); end
        disp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int k;
        reset_cpu();
        poke(12'h000, 16'h2002); poke(12'h001, 16'h3020); poke(12'h002, 16'h5A5A);
        poke(12'h020, 16'hABCD);
        rst = 1'b0;
        k = 0;
        while (!(en === 1'b1 && rdwr === 1'b1) && k < 20) begin tick(); k++; end
        checks++; if (k != 8 || addr !== 12'h020 || dataout !== 16'h5A5A) begin
            errors++; $display("FAIL sta_cycle: got cycle=%0d addr=%h data=%h expected 8 020 5a5a", k, addr, dataout);
        end
        rst = 1'b1; #1;
        checks++; if (en !== 1'b0 || rdwr !== 1'b0 || addr !== 12'h000 || dataout !== 16'h0000) begin
            errors++; $display("FAIL midrst_outputs: got en=%b rdwr=%b addr=%h data=%h expected all zero", en, rdwr, addr, dataout);
        end
        tick();
        checks++; if (mem[12'h020] !== 16'hABCD) begin errors++; $display("FAIL midrst_nocommit: got %h expected abcd", mem[12'h020]); end
        rst = 1'b0;
        tick();
        checks++; if (en !== 1'b1 || rdwr !== 1'b0 || addr !== 12'h000) begin
            errors++; $display("FAIL midrst_refetch: got en=%b rdwr=%b addr=%h expected 1 0 000", en, rdwr, addr);
        end
    endtask

`ifdef ACC_CPU_IRQ_EN
    task automatic test_irq();
        int cyc;
        reset_cpu();
        poke(12'h000, 16'h4005); poke(12'h005, 16'hF080); poke(12'h006, 16'h7001);
        poke(12'h001, 16'h7001);
        kb_valid = 1'b1; kb_data = 8'h00;
        rst = 1'b0;
        run_until_halt(60, cyc);
        kb_valid = 1'b0;
        checks++; if (cyc != 13) begin errors++; $display("FAIL irq_cycles: got %0d expected 13", cyc); end
        checks++; if (mem[0] !== 16'h0006) begin errors++; $display("FAIL irq_saved_pc: got %h expected 0006", mem[0]); end
        checks++; if (dut.ien_q !== 1'b0) begin errors++; $display("FAIL irq_ien: got %b expected 0", dut.ien_q); end
    endtask
`endif

    function automatic int unsigned gen_instr();
        int unsigned sel, ind, op, a;
        logic [11:0] b;
        sel = $urandom_range(0, 6);
        if (sel < 5) begin
            case (sel)
                0: op = 0; 1: op = 1; 2: op = 2; 3: op = 3;
                default: op = 6;
            endcase
            ind = $urandom_range(0, 1);
            a = (ind != 0) ? 32'h110 + $urandom_range(0, 15) : 32'h100 + $urandom_range(0, 15);
            return (ind << 15) | (op << 12) | a;
        end
        b = 12'($urandom & $urandom);
        b[0] = 1'b0;
        return 32'h7000 | 32'(b);
    endfunction

    // Instruction-level reference: executes img[] and returns the cycle total from the timing table
    task automatic model_run(output int cyc);
        int unsigned pc, ac, e, ir, a, opc, i, t, steps;
        bit done, skip;
        pc = 0; ac = 0; e = 0; cyc = 0; steps = 0; done = 0;
        while (!done && steps < 200) begin
            steps++;
            ir = img[pc];
            pc = (pc + 1) % 4096;
            i = ir >> 15; opc = (ir >> 12) & 7; a = ir & 32'hFFF;
            if (opc == 7) begin
                cyc += 3;
                if (i == 0) begin
                    if ((ir & 32'h800) != 0) ac = 0;
                    if ((ir & 32'h400) != 0) e = 0;
                    if ((ir & 32'h200) != 0) ac = ~ac & 32'hFFFF;
                    if ((ir & 32'h100) != 0) e = 1 - e;
                    if ((ir & 32'h080) != 0) begin t = ac & 1; ac = (e << 15) | (ac >> 1); e = t; end
                    if ((ir & 32'h040) != 0) begin t = ac >> 15; ac = ((ac << 1) & 32'hFFFF) | e; e = t; end
                    if ((ir & 32'h020) != 0) ac = (ac + 1) & 32'hFFFF;
                    skip = ((ir & 32'h010) != 0 && ac < 32'h8000) || ((ir & 32'h008) != 0 && ac >= 32'h8000) ||
                           ((ir & 32'h004) != 0 && ac == 0) || ((ir & 32'h002) != 0 && e == 0);
                    if (skip) pc = (pc + 1) % 4096;
                    if ((ir & 1) != 0) done = 1;
                end
            end else begin
                if (i != 0) begin a = img[a] & 32'hFFF; cyc += 1; end
                case (opc)
                    0: begin ac = ac & img[a]; cyc += 5; end
                    1: begin ac = ac + img[a]; e = ac >> 16; ac = ac & 32'hFFFF; cyc += 5; end
                    2: begin ac = img[a]; cyc += 5; end
                    3: begin img[a] = ac; cyc += 4; end
                    4: begin pc = a; cyc += 4; end
                    5: begin img[a] = pc; pc = (a + 1) % 4096; cyc += 5; end
                    default: begin
                        img[a] = (img[a] + 1) & 32'hFFFF;
                        if (img[a] == 0) pc = (pc + 1) % 4096;
                        cyc += 6;
                    end
                endcase
            end
        end
    endtask

    task automatic test_random();
        int len, cyc, exp_cyc, bad, bad_a;
        int unsigned epi [0:4];
        epi[0] = 32'h7000; epi[1] = 32'h3120; epi[2] = 32'h7840; epi[3] = 32'h3121; epi[4] = 32'h7001;
        for (int p = 0; p < 25; p++) begin
            reset_cpu();
            len = $urandom_range(6, 14);
            for (int k = 0; k < 16; k++) begin
                img[32'h100 + k] = ($urandom_range(0, 3) == 0) ? 32'hFFFF : ($urandom & 32'hFFFF);
                img[32'h110 + k] = 32'h100 + $urandom_range(0, 15);
                poke(12'(32'h100 + k), 16'(img[32'h100 + k]));
                poke(12'(32'h110 + k), 16'(img[32'h110 + k]));
            end
            img[32'h120] = 0; img[32'h121] = 0;
            poke(12'h120, 16'h0000); poke(12'h121, 16'h0000);
            for (int k = 0; k < len; k++) begin
                img[k] = gen_instr();
                poke(12'(k), 16'(img[k]));
            end
            for (int k = 0; k < 5; k++) begin
                img[len + k] = epi[k];
                poke(12'(len + k), 16'(epi[k]));
            end
            model_run(exp_cyc);
            rst = 1'b0;
            run_until_halt(600, cyc);
            checks++; if (cyc != exp_cyc) begin
                errors++; $display("FAIL rand_cycles[%0d]: got %0d expected %0d", p, cyc, exp_cyc);
            end
            bad = 0; bad_a = 0;
            for (int a = 32'h100; a <= 32'h121; a++) begin
                if (mem[a] !== 16'(img[a])) begin
                    if (bad == 0) bad_a = a;
                    bad++;
                end
            end
            checks++; if (bad != 0) begin
                errors++; $display("FAIL rand_mem[%0d]: %0d words differ, first at %h got %h expected %h",
                                   p, bad, bad_a, mem[bad_a], 16'(img[bad_a]));
            end
        end
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; ld_we = 1'b0; ld_a = '0; ld_d = '0;
        kb_valid = 1'b0; kb_data = '0; disp_ready = 1'b0;
        test_reset();
        test_basic_program();
        test_indirect();
        test_isz_skip();
        test_io_handshake();
        test_reset_mid_write();
`ifdef ACC_CPU_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
